// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the numerically controlled oscillator.
//   wave_e    : waveform select codes as presented by the I2C slave
//   PHASE_W   : phase accumulator / tuning word width
//   DUTY_W    : square-wave duty threshold width
//   NCO_PI    : pi, used to build the sine ROM at elaboration
package nco_pkg;

   typedef enum logic [1:0] {
      WAVE_SINE   = 2'b00,
      WAVE_SQUARE = 2'b01,
      WAVE_TRI    = 2'b10,
      WAVE_SAW    = 2'b11
   } wave_e;

   localparam int unsigned PHASE_W = 64;
   localparam int unsigned DUTY_W  = 16;
   localparam real         NCO_PI  = 3.14159265358979;

endpackage

// File: rtl/nco_sine_lut.sv
// nco_sine_lut: combinational quarter-wave sine ROM.
//   addr_i : quarter-wave index (LUT_ADDR_W bits)
//   data_o : round((2^(OUT_W-1)-1) * sin(pi/2 * (addr+0.5) / 2^LUT_ADDR_W))
// The half-step offset makes the table symmetric under index inversion, so the
// core can mirror quadrants with a plain bitwise complement of the address.
module nco_sine_lut
   import nco_pkg::*;
#(
   parameter int OUT_W      = 16,
   parameter int LUT_ADDR_W = 8
) (
   input  logic [LUT_ADDR_W-1:0] addr_i,
   output logic [OUT_W-2:0]      data_o
);

   localparam int  DEPTH = 2 ** LUT_ADDR_W;
   localparam real AMP   = real'((2 ** (OUT_W - 1)) - 1);

   logic [OUT_W-2:0] rom [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      localparam real         ANG = (NCO_PI / 2.0) * (real'(i) + 0.5) / real'(DEPTH);
      localparam int unsigned VAL = $rtoi(AMP * $sin(ANG) + 0.5);
      assign rom[i] = VAL[OUT_W-2:0];
   end

   assign data_o = rom[addr_i];

endmodule

// File: rtl/nco_core.sv
// nco_core: numerically controlled oscillator fed by the I2C configuration slave.
//   clk, reset      : clock, synchronous active-high reset
//   nco_enable      : run/stop
//   nco_wave        : 00 sine, 01 square, 10 triangle, 11 sawtooth
//   nco_frequency   : phase increment per clock
//   nco_duty_cycle  : square-wave high threshold on phase[63:48]
//   cfg_busy        : I2C transaction in progress; shadows hold while high
//   wave_out        : offset-binary sample, one per clock
//   wave_valid      : wave_out carries a live sample
//   phase_wrap      : one-cycle pulse on accumulator carry-out
//   phase_msb       : phase[63:48]
// Build option: define NCO_WRAP_UPDATE_EN to restrict shadow loads to the
// phase_wrap cycle (or while stopped) for phase-coherent updates.
module nco_core
   import nco_pkg::*;
#(
   parameter int OUT_W      = 16,
   parameter int LUT_ADDR_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               nco_enable,
   input  logic [1:0]         nco_wave,
   input  logic [PHASE_W-1:0] nco_frequency,
   input  logic [DUTY_W-1:0]  nco_duty_cycle,
   input  logic               cfg_busy,
   output logic [OUT_W-1:0]   wave_out,
   output logic               wave_valid,
   output logic               phase_wrap,
   output logic [15:0]        phase_msb
);

   localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

   // configuration shadows
   logic               en_q;
   wave_e              wave_q;
   logic [PHASE_W-1:0] freq_q;
   logic [DUTY_W-1:0]  duty_q;

   // pipeline state
   logic [PHASE_W-1:0] phase_q;
   logic               wrap_q;
   logic               en_dly_q;
   logic               valid_q;
   logic [OUT_W-1:0]   out_q;

   logic               shadow_ld;
   logic [PHASE_W:0]   phase_sum;
   logic [15:0]        p;
   logic [LUT_ADDR_W-1:0] lut_addr;
   logic [OUT_W-2:0]   lut_val;
   logic [15:0]        tri_t;
   logic [OUT_W-1:0]   shape_d;

   always_comb begin
`ifdef NCO_WRAP_UPDATE_EN
      shadow_ld = !cfg_busy && (wrap_q || !en_q);
`else
      shadow_ld = !cfg_busy;
`endif
      phase_sum = {1'b0, phase_q} + {1'b0, freq_q};
      p         = phase_q[PHASE_W-1 -: 16];
      // odd quadrants run the quarter table backwards
      lut_addr  = p[14] ? ~p[13 -: LUT_ADDR_W] : p[13 -: LUT_ADDR_W];
      tri_t     = p[15] ? {~p[14:0], 1'b0} : {p[14:0], 1'b0};
   end

   nco_sine_lut #(
      .OUT_W      (OUT_W),
      .LUT_ADDR_W (LUT_ADDR_W)
   ) u_lut (
      .addr_i (lut_addr),
      .data_o (lut_val)
   );

   always_comb begin
      shape_d = MID;
      case (wave_q)
         WAVE_SINE:   shape_d = p[15] ? (MID - {1'b0, lut_val}) : (MID + {1'b0, lut_val});
         WAVE_SQUARE: shape_d = (p < duty_q) ? '1 : '0;
         WAVE_TRI:    shape_d = tri_t[15 -: OUT_W];
         WAVE_SAW:    shape_d = p[15 -: OUT_W];
         default:     shape_d = MID;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q     <= 1'b0;
         wave_q   <= WAVE_SINE;
         freq_q   <= '0;
         duty_q   <= '0;
         phase_q  <= '0;
         wrap_q   <= 1'b0;
         en_dly_q <= 1'b0;
         valid_q  <= 1'b0;
         out_q    <= MID;
      end else begin
         if (shadow_ld) begin
            en_q   <= nco_enable;
            wave_q <= wave_e'(nco_wave);
            freq_q <= nco_frequency;
            duty_q <= nco_duty_cycle;
         end
         if (en_q) begin
            phase_q <= phase_sum[PHASE_W-1:0];
            wrap_q  <= phase_sum[PHASE_W];
         end else begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
         end
         // en_dly_q tracks which phase_q values came from a running accumulator
         en_dly_q <= en_q;
         valid_q  <= en_dly_q;
         out_q    <= en_dly_q ? shape_d : MID;
      end
   end

   assign wave_out   = out_q;
   assign wave_valid = valid_q;
   assign phase_wrap = wrap_q;
   assign phase_msb  = phase_q[PHASE_W-1 -: 16];

endmodule

// File: tb/tb_nco_core.sv
module tb_nco_core;

   localparam int OUT_W = 16;
   localparam int LAW   = 8;
   localparam int MID   = 1 << (OUT_W - 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [1:0]        wv;
   logic [63:0]       freq;
   logic [15:0]       duty;
   logic              busy;
   logic [OUT_W-1:0]  wave_out;
   logic              wave_valid;
   logic              phase_wrap;
   logic [15:0]       phase_msb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nco_core #(.OUT_W(OUT_W), .LUT_ADDR_W(LAW)) dut (
      .clk            (clk),
      .reset          (rst),
      .nco_enable     (en),
      .nco_wave       (wv),
      .nco_frequency  (freq),
      .nco_duty_cycle (duty),
      .cfg_busy       (busy),
      .wave_out       (wave_out),
      .wave_valid     (wave_valid),
      .phase_wrap     (phase_wrap),
      .phase_msb      (phase_msb)
   );

   // waveform value for a 16-bit phase, straight from the shaping rules
   function automatic int ref_wave(int w, int p, int d);
      int  n, i, l;
      real amp;
      n = 1 << LAW;
      case (w)
         0: begin
            i = (p >> (14 - LAW)) % n;
            if (((p >> 14) & 1) == 1) i = n - 1 - i;
            amp = real'(MID - 1);
            l = $rtoi(amp * $sin(3.14159265358979 * 0.5 * (real'(i) + 0.5) / real'(n)) + 0.5);
            return (p >= 32768) ? MID - l : MID + l;
         end
         1: return (p < d) ? (1 << OUT_W) - 1 : 0;
         2: return ((p < 32768) ? 2 * p : 2 * (65535 - p)) >> (16 - OUT_W);
         default: return p >> (16 - OUT_W);
      endcase
   endfunction

   task automatic chk(string name, longint act, longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      bit vld;
      int wave;
      bit wrap;
      int msb;
   } exp_t;

   exp_t exp_q[$];

   bit          m_en, m_en1, m_wrap;
   int          m_wave, m_duty;
   logic [63:0] m_freq, m_ph;
   bit          m_vld;
   int          m_out;

   always @(posedge clk) begin
      exp_t        e;
      bit          ld;
      logic [64:0] s;
      if (rst) begin
         m_en = 0; m_en1 = 0; m_wrap = 0; m_wave = 0; m_duty = 0;
         m_freq = '0; m_ph = '0; m_vld = 0; m_out = MID;
      end else begin
`ifdef NCO_WRAP_UPDATE_EN
         ld = !busy && (m_wrap || !m_en);
`else
         ld = !busy;
`endif
         // sample is formed from the phase present before this edge
         m_vld = m_en1;
         m_out = m_en1 ? ref_wave(m_wave, int'(m_ph[63:48]), m_duty) : MID;
         m_en1 = m_en;
         if (m_en) begin
            s      = {1'b0, m_ph} + {1'b0, m_freq};
            m_ph   = s[63:0];
            m_wrap = s[64];
         end else begin
            m_ph   = '0;
            m_wrap = 0;
         end
         if (ld) begin
            m_en = en; m_wave = int'(wv); m_freq = freq; m_duty = int'(duty);
         end
      end
      e.vld  = m_vld;
      e.wave = m_out;
      e.wrap = m_wrap;
      e.msb  = int'(m_ph[63:48]);
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         chk("sample{valid,wave}", {wave_valid, wave_out}, {e.vld, e.wave[OUT_W-1:0]});
         chk("phase{wrap,msb}", {phase_wrap, phase_msb}, {e.wrap, e.msb[15:0]});
      end
   end

   // ---------------- stimulus ----------------
   task automatic run(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_wraps(int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (phase_wrap) c++;
      end
   endtask

   function automatic logic [63:0] rnd_freq();
      case ($urandom_range(0, 3))
         0: return {$urandom, $urandom};
         1: return 64'd1 << $urandom_range(54, 63);
         2: return {$urandom_range(1, 255), 56'd0};
         default: return 64'd0;
      endcase
   endfunction

   initial begin
      int c;
      int hi;
      rst = 1; en = 0; wv = 2'b00; freq = '0; duty = '0; busy = 0;
      run(3);
      chk("reset_wave", wave_out, MID);
      chk("reset_valid", wave_valid, 0);
      chk("reset_wrap", phase_wrap, 0);
      chk("reset_msb", phase_msb, 0);
      rst = 0;
      run(2);

      // sawtooth, first-sample latency
      wv = 2'b11; freq = 64'd1 << 60; en = 1;
      run(2);
      chk("lat_valid_low_edge2", wave_valid, 0);
      run(1);
      chk("lat_valid_edge3", wave_valid, 1);
      chk("lat_first_saw", wave_out, 16'h1000);
      run(5);
      count_wraps(48, c);
      chk("saw_wrap_count48", c, 3);

      // square duty 1/4, then duty 0, then near-full duty
      wv = 2'b01; duty = 16'h4000;
      run(4);
      hi = 0;
      repeat (32) begin
         @(negedge clk);
         if (wave_out == 16'hFFFF) hi++;
      end
      chk("square_high_count32", hi, 8);
      duty = 16'h0000;
      run(20);
      duty = 16'hFFFF; freq = 64'h0FFF_0000_0000_0000;
      run(40);

      // sine, one full period plus, and triangle
      wv = 2'b00; freq = 64'd1 << 56;
      run(300);
      wv = 2'b10; freq = 64'h0123_4567_89AB_CDEF;
      run(60);

      // held configuration while busy, released afterwards
      wv = 2'b11; freq = 64'd1 << 60;
      run(10);
      busy = 1; freq = 64'd1 << 61;
      count_wraps(32, c);
      chk("busy_hold_wraps32", c, 2);
      busy = 0;
      run(3);
      count_wraps(32, c);
      chk("busy_release_wraps32", c, 4);

      // disable, re-enable, reset mid-run
      en = 0;
      run(10);
      chk("disabled_wave_mid", wave_out, MID);
      en = 1;
      run(20);
      rst = 1;
      run(1);
      chk("midrun_reset_wave", wave_out, MID);
      chk("midrun_reset_valid", wave_valid, 0);
      chk("midrun_reset_msb", phase_msb, 0);
      rst = 0;
      run(10);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) wv = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) freq = rnd_freq();
         if ($urandom_range(0, 9) == 0) duty = 16'($urandom);
         if ($urandom_range(0, 7) == 0) busy = ~busy;
         if ($urandom_range(0, 49) == 0) en = ~en;
         rst = ($urandom_range(0, 299) == 0);
         run(1);
      end
      rst = 0;
      run(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nco_core.md
Name: nco_core

Overview:
- Numerically controlled oscillator that consumes the configuration produced by the I2C slave: enable, wave select, 64-bit tuning word and 16-bit duty cycle.
- Shadow-registers the configuration, runs a 64-bit phase accumulator and produces one registered waveform sample per clock for the DAC interface downstream.
- Shadows load only while the I2C transaction flag is low, so a partially received configuration is never applied.

Parameters:
- OUT_W, 16, sample width (8..16), offset-binary.
- LUT_ADDR_W, 8, address width of the quarter-wave sine ROM (6..12).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- nco_enable  in  1  run/stop from the I2C slave
- nco_wave  in  2  waveform select: 00 sine, 01 square, 10 triangle, 11 sawtooth
- nco_frequency  in  64  phase increment per clk
- nco_duty_cycle  in  16  square high threshold on phase[63:48]
- cfg_busy  in  1  I2C transaction in progress (slave's start flag)
- wave_out  out  OUT_W  sample, offset-binary
- wave_valid  out  1  wave_out is a live sample
- phase_wrap  out  1  one-cycle pulse on accumulator carry-out
- phase_msb  out  16  phase[63:48], for debug/sync

Behaviour:
- Reset is synchronous and active-high. All state clears on the next clk edge with reset=1: shadows 0 (disabled, sine, freq 0, duty 0), phase 0, wave_out 2^(OUT_W-1), wave_valid 0, phase_wrap 0, phase_msb 0.
- Reset asserted mid-run takes effect at that edge. The first sample after reset requires en_s reloaded.
- Shadow load: en_s/wave_s/freq_s/duty_s <= inputs on every cycle with cfg_busy=0. Shadows hold while cfg_busy=1.
- Stage 1, phase accumulator:
  - en_s=1: phase <= phase + freq_s mod 2^64. phase_wrap <= carry-out.
  - en_s=0: phase <= 0, phase_wrap <= 0.
- Stage 2, waveform registered from the stage-1 phase. Let p = phase[63:48].
  - Sine: a = p[13 -: LUT_ADDR_W]. LUT[i] = round((2^(OUT_W-1)-1)*sin(pi/2*(i+0.5)/2^LUT_ADDR_W)).
    - Quadrant p[15:14] 00: mid+LUT[a]. 01: mid+LUT[~a]. 10: mid-LUT[a]. 11: mid-LUT[~a]. mid = 2^(OUT_W-1).
  - Square: (p < duty_s) ? 2^OUT_W-1 : 0. Duty 0 gives constant 0. Duty 0xFFFF is high except p=0xFFFF.
  - Triangle: t = p[15] ? {~p[14:0],1'b0} : {p[14:0],1'b0}. Output t[15 -: OUT_W].
  - Sawtooth: p[15 -: OUT_W].
  - en_s=0: wave_out <= mid.
- wave_valid <= en_s delayed one cycle, aligned with wave_out.
- Latency:
  - Input change with cfg_busy=0 reaches the shadow at edge 1.
  - The first accumulated phase appears at edge 2.
  - The matching wave_out appears at edge 3.
- Boundaries:
  - freq_s=0: phase frozen at 0, output constant.
  - freq_s>=2^63: aliased, accepted with no special handling.
  - Wave select changed while running: takes effect on the next sample, phase continuous.
  - Disable to enable: phase restarts from 0.

Optional Feature:
- NCO_WRAP_UPDATE_EN
- Defined: shadows load only when cfg_busy=0 AND (phase_wrap=1 in that cycle OR en_s=0). Updates are phase-coherent, no mid-period glitch. Disabling while running also waits for a wrap.
- Undefined: shadows load on any cycle with cfg_busy=0, as in Behaviour.

Decomposition:
- Package nco_pkg holds:
  - Wave codes WAVE_SINE=2'b00, WAVE_SQUARE=2'b01, WAVE_TRI=2'b10, WAVE_SAW=2'b11.
  - PHASE_W=64, DUTY_W=16.
- Sub-module nco_sine_lut: synchronous-free combinational quarter-wave ROM. Parameterised by OUT_W/LUT_ADDR_W, table generated at elaboration.
- Accumulator and shaping stay in nco_core.

Test Plan:
- Saw, freq=2^60, enable, cfg_busy=0 -> wave_out 0x0000,0x1000,…,0xF000 repeating; phase_wrap every 16 cycles; wave_valid high from 3rd edge.
- Square, freq=2^60, duty=0x4000 -> 4 samples 0xFFFF, 12 samples 0x0000 per period. Duty=0 -> always 0x0000.
- Sine, freq=2^56 -> wave(p)+wave(p+0x8000)=0x10000 for every sample; first-quadrant samples strictly non-decreasing; peak 0x7FFF+mid region.
- cfg_busy=1, change freq to 2^61 -> period stays 16. cfg_busy falls -> period becomes 8 within 3 cycles.
- Disable mid-run, then reset pulse mid-run -> wave_out=0x8000, wave_valid=0, phase_msb=0 next edge.
- With NCO_WRAP_UPDATE_EN: freq change at phase 0x3000 -> old increment persists until the phase_wrap cycle; without the macro, applied next edge.
